mult_share_arbiter: RTL and testbench

Round-robin scheduler that shares one multi-cycle multiplier (the FBDSP `wrapper` datapath: `start`/`sign`/`aa`/`bb` in, `out` after a fixed latency) among `NREQ` requesters. It enforces the multiplier's initiation interval, holds operands stable between issues, and tracks in-flight operations so each product returns tagged with its requester's index. It sits directly in front of the multiplier instance, between it and the client logic.

---
 rtl/mult_share_arbiter.sv | 118 +++++++++++
 tb/tb_mult_share_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin scheduler sharing one pipelined multiplier
// Grants one requester per issue slot and tags each operation so products return with their owner's id.
module mult_share_arbiter #(
  parameter int N    = 8,
  parameter int M    = 8,
  parameter int NREQ = 4,
  parameter int II   = 4,
  parameter int LAT  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ-1:0]         req_sign_i,
  input  logic [NREQ*N-1:0]       req_a_i,
  input  logic [NREQ*M-1:0]       req_b_i,
  output logic                    mult_start_o,
  output logic                    mult_sign_o,
  output logic [N-1:0]            mult_aa_o,
  output logic [M-1:0]            mult_bb_o,
  input  logic [N+M-1:0]          mult_out_i,
  output logic                    rsp_valid_o,
  output logic [$clog2(NREQ)-1:0] rsp_id_o,
  output logic [N+M-1:0]          rsp_data_o,
  output logic                    idle_o
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = (II > 1) ? $clog2(II) : 1;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        ptr_q;
  logic                 slot_open;
  logic                 hs;
  logic                 found;
  logic [IW-1:0]        win_idx;
  logic [IW:0]          cand;
  logic                 mult_start_q;
  logic                 mult_sign_q;
  logic [N-1:0]         mult_aa_q;
  logic [M-1:0]         mult_bb_q;
  logic [LAT:0]         tag_v_q;
  logic [LAT:0][IW-1:0] tag_id_q;
  logic                 rsp_valid_q;
  logic [IW-1:0]        rsp_id_q;
  logic [N+M-1:0]       rsp_data_q;

  assign slot_open = (cnt_q == '0);

  // Search starts just past the last winner; cand carries one extra bit so the wrap is a single subtract.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!found && req_valid_i[cand[IW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (found && slot_open && rst_ni) req_ready_o[win_idx] = 1'b1;
  end

  assign hs = |(req_valid_i & req_ready_o);

  always_comb begin
    cnt_d = cnt_q;
    if (hs) cnt_d = CW'(II - 1);
    else if (!slot_open) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      ptr_q        <= IW'(NREQ - 1);
      mult_start_q <= 1'b0;
      mult_sign_q  <= 1'b0;
      mult_aa_q    <= '0;
      mult_bb_q    <= '0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
    end else begin
      cnt_q        <= cnt_d;
      mult_start_q <= hs;
      if (hs) begin
        ptr_q       <= win_idx;
        mult_sign_q <= req_sign_i[win_idx];
        mult_aa_q   <= req_a_i[win_idx*N +: N];
        mult_bb_q   <= req_b_i[win_idx*M +: M];
      end
      // Stage LAT lines up with the cycle in which mult_out_i holds that operation's product.
      tag_v_q     <= {tag_v_q[LAT-1:0], hs};
      tag_id_q    <= {tag_id_q[LAT-1:0], win_idx};
      rsp_valid_q <= tag_v_q[LAT];
      if (tag_v_q[LAT]) begin
        rsp_data_q <= mult_out_i;
        rsp_id_q   <= tag_id_q[LAT];
      end
    end
  end

  assign mult_start_o = mult_start_q;
  assign mult_sign_o  = mult_sign_q;
  assign mult_aa_o    = mult_aa_q;
  assign mult_bb_o    = mult_bb_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_data_o   = rsp_data_q;
  assign idle_o       = slot_open & ~|tag_v_q & ~rsp_valid_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - directed and random bench for mult_share_arbiter
// Two instances: II=4 for arbitration/reset/random scenarios, II=1 for the streaming sweep.
module tb_mult_share_arbiter;
  localparam int N = 8, M = 8, NREQ = 4, LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0]  req_valid, req_ready, req_sign;
  logic [31:0] req_a, req_b;
  logic        mult_start, mult_sign, rsp_valid, idle;
  logic [7:0]  mult_aa, mult_bb;
  logic [15:0] mult_out, rsp_data;
  logic [1:0]  rsp_id;

  logic [3:0]  b_req_valid, b_req_ready, b_req_sign;
  logic [31:0] b_req_a, b_req_b;
  logic        b_mult_start, b_mult_sign, b_rsp_valid, b_idle;
  logic [7:0]  b_mult_aa, b_mult_bb;
  logic [15:0] b_mult_out, b_rsp_data;
  logic [1:0]  b_rsp_id;

  mult_share_arbiter #(.N(N), .M(M), .NREQ(NREQ), .II(4), .LAT(LAT)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_sign_i(req_sign),
    .req_a_i(req_a), .req_b_i(req_b),
    .mult_start_o(mult_start), .mult_sign_o(mult_sign), .mult_aa_o(mult_aa), .mult_bb_o(mult_bb),
    .mult_out_i(mult_out),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .idle_o(idle)
  );

  mult_share_arbiter #(.N(N), .M(M), .NREQ(NREQ), .II(1), .LAT(LAT)) u_dut_ii1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_sign_i(b_req_sign),
    .req_a_i(b_req_a), .req_b_i(b_req_b),
    .mult_start_o(b_mult_start), .mult_sign_o(b_mult_sign), .mult_aa_o(b_mult_aa), .mult_bb_o(b_mult_bb),
    .mult_out_i(b_mult_out),
    .rsp_valid_o(b_rsp_valid), .rsp_id_o(b_rsp_id), .rsp_data_o(b_rsp_data), .idle_o(b_idle)
  );

  function automatic logic [15:0] mul(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    if (s) begin
      sa = $signed({{8{a[7]}}, a});
      sb = $signed({{8{b[7]}}, b});
      return 16'(sa * sb);
    end
    return {8'h00, a} * {8'h00, b};
  endfunction

  // Multiplier stand-ins: product visible LAT cycles after the start cycle, garbage otherwise.
  logic [15:0] a_pipe [LAT];
  logic [15:0] b_pipe [LAT];
  always @(posedge clk) begin
    a_pipe[0] <= mult_start ? mul(mult_sign, mult_aa, mult_bb) : 16'hDEAD;
    b_pipe[0] <= b_mult_start ? mul(b_mult_sign, b_mult_aa, b_mult_bb) : 16'hBEEF;
    for (int i = 1; i < LAT; i++) begin
      a_pipe[i] <= a_pipe[i-1];
      b_pipe[i] <= b_pipe[i-1];
    end
  end
  assign mult_out   = a_pipe[LAT-1];
  assign b_mult_out = b_pipe[LAT-1];

  logic [15:0] rr_exp [4] = '{16'h0030, 16'h0044, 16'h005A, 16'h0072};
  logic [7:0]  ii_a [8]   = '{8'h02, 8'h10, 8'hFF, 8'h80, 8'h07, 8'h0F, 8'hFF, 8'h80};
  logic [7:0]  ii_b [8]   = '{8'h03, 8'h10, 8'hFF, 8'h02, 8'h09, 8'h11, 8'h01, 8'h80};
  logic        ii_s [8]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] ii_p [8]   = '{16'h0006, 16'h0100, 16'hFE01, 16'h0100,
                              16'h003F, 16'h00FF, 16'hFFFF, 16'h4000};

  task automatic wait_idle();
    int w = 0;
    while (idle !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    if (idle !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_wait got %b exp 1", idle);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF; req_sign = 4'hF; req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF;
    b_req_valid = '0; b_req_sign = '0; b_req_a = '0; b_req_b = '0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++; $display("FAIL rst_ready got %b exp 0000", req_ready);
    end
    vectors++;
    if ({mult_start, mult_sign, mult_aa, mult_bb} !== 18'h0) begin
      miscompares++; $display("FAIL rst_mult got %b/%b/%h/%h exp zeros", mult_start, mult_sign, mult_aa, mult_bb);
    end
    vectors++;
    if ({rsp_valid, rsp_id, rsp_data} !== 19'h0) begin
      miscompares++; $display("FAIL rst_rsp got %b/%0d/%h exp zeros", rsp_valid, rsp_id, rsp_data);
    end
    req_valid = '0; req_sign = '0; req_a = '0; req_b = '0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (idle !== 1'b1 || b_idle !== 1'b1) begin
      miscompares++; $display("FAIL rst_idle got %b/%b exp 1/1", idle, b_idle);
    end
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++; $display("FAIL rst_noreq_ready got %b exp 0000", req_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    logic       exp_st, exp_rv;
    int         j;
    wait_idle();
    @(negedge clk);
    req_a = {8'h13, 8'h12, 8'h11, 8'h10};
    req_b = {8'h06, 8'h05, 8'h04, 8'h03};
    req_sign = 4'h0;
    req_valid = 4'hF;
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 17) req_valid = 4'h0;
      #1;
      exp_rdy = (k % 4 == 0 && k <= 16) ? 4'(1 << ((k / 4) % 4)) : 4'b0000;
      exp_st  = (k % 4 == 1 && k <= 17);
      exp_rv  = (k >= 6 && (k - 6) % 4 == 0 && k <= 22);
      vectors++;
      if (req_ready !== exp_rdy) begin
        miscompares++; $display("FAIL rr_ready k=%0d got %b exp %b", k, req_ready, exp_rdy);
      end
      vectors++;
      if (mult_start !== exp_st) begin
        miscompares++; $display("FAIL rr_start k=%0d got %b exp %b", k, mult_start, exp_st);
      end
      vectors++;
      if (rsp_valid !== exp_rv) begin
        miscompares++; $display("FAIL rr_rsp_valid k=%0d got %b exp %b", k, rsp_valid, exp_rv);
      end
      if (exp_rv) begin
        j = ((k - 6) / 4) % 4;
        vectors++;
        if (rsp_id !== 2'(j) || rsp_data !== rr_exp[j]) begin
          miscompares++; $display("FAIL rr_rsp k=%0d got id %0d data %h exp id %0d data %h", k, rsp_id, rsp_data, j, rr_exp[j]);
        end
      end
    end
  endtask

  task automatic single_op(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic [15:0] exp);
    wait_idle();
    @(negedge clk);
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
    req_sign[id] = s;
    #1;
    vectors++;
    if (req_ready !== 4'(1 << id)) begin
      miscompares++; $display("FAIL op%0d_ready got %b exp %b", id, req_ready, 4'(1 << id));
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = '0;
      #1;
      vectors++;
      if (mult_start !== (k == 1)) begin
        miscompares++; $display("FAIL op%0d_start k=%0d got %b", id, k, mult_start);
      end
      if (k == 1) begin
        vectors++;
        if (mult_aa !== a || mult_bb !== b || mult_sign !== s) begin
          miscompares++; $display("FAIL op%0d_operands got %h/%h/%b exp %h/%h/%b", id, mult_aa, mult_bb, mult_sign, a, b, s);
        end
      end
      vectors++;
      if (rsp_valid !== (k == 6)) begin
        miscompares++; $display("FAIL op%0d_rsp_valid k=%0d got %b", id, k, rsp_valid);
      end
      if (k >= 6) begin
        vectors++;
        if (rsp_id !== 2'(id) || rsp_data !== exp) begin
          miscompares++; $display("FAIL op%0d_rsp k=%0d got id %0d data %h exp id %0d data %h", id, k, rsp_id, rsp_data, id, exp);
        end
      end
    end
  endtask

  task automatic test_single();
    single_op(0, 8'h12, 8'h34, 1'b0, 16'h03A8);
  endtask

  task automatic test_signed();
    single_op(2, 8'hFD, 8'h05, 1'b1, 16'hFFF1);
    single_op(2, 8'hFD, 8'h05, 1'b0, 16'h04F1);
  endtask

  task automatic test_reset_midflight();
    wait_idle();
    @(negedge clk);
    req_a = 32'h0000_2100; req_b = 32'h0000_0200; req_sign = '0;
    req_valid = 4'b0010;
    repeat (4) begin
      @(negedge clk);
      req_valid = '0;
    end
    req_a[23:16] = 8'h33; req_b[23:16] = 8'h04;
    req_valid = 4'b0100;
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++; $display("FAIL mid_second_ready got %b exp 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b1001;
    #1;
    vectors++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || mult_start !== 1'b0) begin
      miscompares++; $display("FAIL mid_in_reset got ready %b rsp %b start %b exp 0000/0/0", req_ready, rsp_valid, mult_start);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (rsp_valid !== 1'b0 || mult_start !== 1'b0 || {mult_sign, mult_aa, mult_bb} !== 17'h0 ||
          rsp_id !== 2'd0 || rsp_data !== 16'h0 || idle !== 1'b1) begin
        miscompares++;
        $display("FAIL mid_after_reset k=%0d got rsp %b start %b aa %h bb %h id %0d data %h idle %b exp quiescent",
                 k, rsp_valid, mult_start, mult_aa, mult_bb, rsp_id, rsp_data, idle);
      end
    end
    req_a = 32'h0000_0003; req_b = 32'h0000_0007;
    req_valid = 4'b1001;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++; $display("FAIL mid_first_grant got %b exp 0001", req_ready);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      req_valid = '0;
    end
    #1;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'h0015) begin
      miscompares++; $display("FAIL mid_post_rsp got %b/%0d/%h exp 1/0/0015", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_ii1_sweep();
    @(negedge clk);
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 8) begin
        b_req_valid = 4'b0010;
        b_req_a[15:8] = ii_a[k];
        b_req_b[15:8] = ii_b[k];
        b_req_sign[1] = ii_s[k];
      end else begin
        b_req_valid = '0;
      end
      #1;
      vectors++;
      if (b_req_ready !== ((k < 8) ? 4'b0010 : 4'b0000)) begin
        miscompares++; $display("FAIL ii1_ready k=%0d got %b", k, b_req_ready);
      end
      vectors++;
      if (b_mult_start !== (k >= 1 && k <= 8)) begin
        miscompares++; $display("FAIL ii1_start k=%0d got %b", k, b_mult_start);
      end
      vectors++;
      if (b_rsp_valid !== (k >= 6 && k <= 13)) begin
        miscompares++; $display("FAIL ii1_rsp_valid k=%0d got %b", k, b_rsp_valid);
      end
      if (k >= 6 && k <= 13) begin
        vectors++;
        if (b_rsp_id !== 2'd1 || b_rsp_data !== ii_p[k-6]) begin
          miscompares++; $display("FAIL ii1_rsp k=%0d got id %0d data %h exp id 1 data %h", k, b_rsp_id, b_rsp_data, ii_p[k-6]);
        end
      end
      if (k == 14) begin
        vectors++;
        if (b_idle !== 1'b1) begin
          miscompares++; $display("FAIL ii1_idle got %b exp 1", b_idle);
        end
      end
    end
  endtask

  task automatic test_random();
    int          q_id[$];
    logic [15:0] q_data[$];
    int          q_cyc[$];
    int          hs_count = 0;
    int          last_hs = -1000;
    int          ptr_m = NREQ - 1;
    int          idx, eid, ec;
    logic [15:0] ed;
    logic [3:0]  exp_rdy;
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3000 && (hs_count < 200 || q_id.size() > 0); c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        vectors++;
        if (q_id.size() == 0) begin
          miscompares++; $display("FAIL rnd_unexpected_rsp id %0d data %h", rsp_id, rsp_data);
        end else begin
          eid = q_id.pop_front(); ed = q_data.pop_front(); ec = q_cyc.pop_front();
          if (rsp_id !== 2'(eid) || rsp_data !== ed || cyc != ec + LAT + 2) begin
            miscompares++;
            $display("FAIL rnd_rsp got id %0d data %h cyc %0d exp id %0d data %h cyc %0d", rsp_id, rsp_data, cyc, eid, ed, ec + LAT + 2);
          end
        end
      end
      if (hs_count < 200) begin
        req_valid = 4'($urandom_range(0, 15));
        req_a = $urandom; req_b = $urandom; req_sign = 4'($urandom);
      end else begin
        req_valid = '0;
      end
      #1;
      exp_rdy = '0;
      if (cyc - last_hs >= 4) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (ptr_m + k) % NREQ;
          if (req_valid[idx] && exp_rdy == 4'b0000) exp_rdy = 4'(1 << idx);
        end
      end
      vectors++;
      if (req_ready !== exp_rdy) begin
        miscompares++; $display("FAIL rnd_ready cyc %0d got %b exp %b valid %b", cyc, req_ready, exp_rdy, req_valid);
      end
      if ((req_ready & req_valid) != 4'b0000) begin
        idx = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i] && req_valid[i]) idx = i;
        vectors++;
        if (cyc - last_hs < 4) begin
          miscompares++; $display("FAIL rnd_spacing got %0d exp >=4", cyc - last_hs);
        end
        q_id.push_back(idx);
        q_data.push_back(mul(req_sign[idx], req_a[idx*8 +: 8], req_b[idx*8 +: 8]));
        q_cyc.push_back(cyc);
        last_hs = cyc;
        ptr_m = idx;
        hs_count++;
      end
    end
    req_valid = '0;
    vectors++;
    if (hs_count != 200 || q_id.size() != 0) begin
      miscompares++; $display("FAIL rnd_drain got %0d issued %0d pending exp 200 issued 0 pending", hs_count, q_id.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_signed();
    test_reset_midflight();
    test_ii1_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
